map_scroller: RTL and testbench
===============================

MAP_SCROLLER -- requirements
Module: map_scroller

Interface
REQ-001 SHALL have parameter MAP_W, default 750, source map width in pixels.
REQ-002 SHALL have parameter MAP_H, default 240, source map height in pixels.
REQ-003 SHALL have parameters WIN_X0/WIN_Y0, defaults 130/180, screen origin of viewport.
REQ-004 SHALL have parameters WIN_W/WIN_H, defaults 510/120, viewport size; MAP_W>=WIN_W, MAP_H>=WIN_H.
REQ-005 SHALL have parameter STEP, default 1, pixels moved per frame.
REQ-006 SHALL have parameter ACTIVE_STATUS, default 4'd3, game status enabling the block.
REQ-007 SHALL have parameter ADDR_W, default 20, ROM address width.
REQ-008 Clk  in  1  system clock; Reset  in  1  asynchronous, active-high reset.
REQ-009 frame_clk  in  1  vertical-sync frame clock, asynchronous level.
REQ-010 status  in  4  game state; keycode  in  8  current key.
REQ-011 DrawX, DrawY  in  10 each  current pixel coordinates.
REQ-012 pan_req  in  1  pan request pulse; pan_x, pan_y  in  10 each  pan target offset.
REQ-013 pan_busy  out  1  pan in progress; pan_done  out  1  one-Clk arrival pulse.
REQ-014 scroll_x, scroll_y  out  10 each  current viewport offset into map.
REQ-015 is_map  out  1  pixel inside viewport; map_address  out  ADDR_W  ROM address.

Function
REQ-016 Frame tick SHALL be a one-Clk pulse, registered, on each frame_clk rising edge (two-flop detect).
REQ-017 States SHALL be INACTIVE, MANUAL, PAN; status!=ACTIVE_STATUS forces INACTIVE from any state next Clk.
REQ-018 INACTIVE: scroll_x=scroll_y=0, pan_busy=0; moves to MANUAL when status==ACTIVE_STATUS.
REQ-019 MANUAL, per tick: keycode 0x07 scroll_x+=STEP, 0x04 scroll_x-=STEP, 0x16 scroll_y+=STEP, 0x1A scroll_y-=STEP, others hold.
REQ-020 Scroll SHALL clamp to [0, MAP_W-WIN_W] and [0, MAP_H-WIN_H]; arithmetic in 11 bits signed, no wrap-around.
REQ-021 pan_req SHALL be accepted only in MANUAL; targets clamped to legal range and latched; state -> PAN, pan_busy=1 next Clk.
REQ-022 pan_req in INACTIVE or PAN SHALL be ignored; pan_req coincident with a tick: tick ignored, movement starts next tick.
REQ-023 PAN, per tick: each axis moves min(STEP, distance) toward target; keycode ignored.
REQ-024 When both axes equal target: pan_done=1 for one Clk, pan_busy=0, state -> MANUAL; target equal to current completes on first tick.
REQ-025 Leaving ACTIVE_STATUS mid-pan SHALL abort: no pan_done, scroll reset to 0.
REQ-026 is_map=1 iff status==ACTIVE_STATUS and WIN_X0<=DrawX<WIN_X0+WIN_W and WIN_Y0<=DrawY<WIN_Y0+WIN_H.
REQ-027 map_address=(DrawY-WIN_Y0+scroll_y)*MAP_W+(DrawX-WIN_X0+scroll_x) when is_map, else 0.
REQ-028 is_map and map_address SHALL be registered: exactly one Clk latency from DrawX/DrawY.

Reset
REQ-029 Reset SHALL asynchronously force INACTIVE, scroll 0, pan_busy=0, pan_done=0, is_map=0, map_address=0, edge-detect flops 0.
REQ-030 First tick after Reset release SHALL be no earlier than the first frame_clk rising edge sampled after release.

Configuration
REQ-031 With MAP_SCROLL_Y_EN defined: vertical scrolling and vertical pan per REQ-019/023.
REQ-032 Without MAP_SCROLL_Y_EN: scroll_y constant 0, keys 0x16/0x1A ignored, pan_y ignored, pan completes on X only.

Verification
REQ-033 Reset, status=3, keycode 0x07 held 300 ticks -> scroll_x rises 1/tick, saturates 240.
REQ-034 scroll_x=0, keycode 0x04 for 5 ticks -> scroll_x stays 0, no underflow.
REQ-035 status=3, scroll=(0,0), pan_req with (100,50), STEP=1 -> pan_busy next Clk, pan_done after tick 100, scroll=(100,50); keys ignored meanwhile.
REQ-036 pan_req (900,900) -> target clamped, final scroll=(240,120), one pan_done pulse.
REQ-037 Mid-pan status->2 -> next Clk INACTIVE, scroll (0,0), pan_busy 0, no pan_done.
REQ-038 scroll=(10,5), DrawX=130, DrawY=180 -> next Clk is_map=1, map_address=5*750+10=3760; DrawX=640 -> is_map=0, address 0.

Source files
------------

// File: rtl/map_scroller.sv
// Scrolling viewport into a tile-map ROM: manual key scroll, timed pan, pixel address gen.
// Build with MAP_SCROLL_Y_EN defined to enable vertical scroll and vertical pan.
module map_scroller #(
  parameter int MAP_W = 750,
  parameter int MAP_H = 240,
  parameter int WIN_X0 = 130,
  parameter int WIN_Y0 = 180,
  parameter int WIN_W = 510,
  parameter int WIN_H = 120,
  parameter int STEP = 1,
  parameter logic [3:0] ACTIVE_STATUS = 4'd3,
  parameter int ADDR_W = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [3:0]        status,
  input  logic [7:0]        keycode,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pan_req,
  input  logic [9:0]        pan_x,
  input  logic [9:0]        pan_y,
  output logic              pan_busy,
  output logic              pan_done,
  output logic [9:0]        scroll_x,
  output logic [9:0]        scroll_y,
  output logic              is_map,
  output logic [ADDR_W-1:0] map_address
);

  localparam logic [1:0] S_INACTIVE = 2'd0;
  localparam logic [1:0] S_MANUAL   = 2'd1;
  localparam logic [1:0] S_PAN      = 2'd2;

  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_UP    = 8'h1A;

  localparam logic signed [10:0] X_MAX  = 11'(MAP_W - WIN_W);
  localparam logic signed [10:0] Y_MAX  = 11'(MAP_H - WIN_H);
  localparam logic signed [10:0] STEP_S = 11'(STEP);
  localparam logic [10:0]        STEP_U = 11'(STEP);

  localparam logic [10:0] X_LO = 11'(WIN_X0);
  localparam logic [10:0] X_HI = 11'(WIN_X0 + WIN_W);
  localparam logic [10:0] Y_LO = 11'(WIN_Y0);
  localparam logic [10:0] Y_HI = 11'(WIN_Y0 + WIN_H);

`ifdef MAP_SCROLL_Y_EN
  localparam bit Y_EN = 1'b1;
`else
  localparam bit Y_EN = 1'b0;
`endif

  logic       fc_meta;
  logic       fc_sync;
  logic       fc_prev;
  logic       tick;

  logic [1:0] state;
  logic [1:0] state_n;
  logic [9:0] sx_n;
  logic [9:0] sy_n;
  logic [9:0] tgt_x;
  logic [9:0] tgt_y;
  logic [9:0] tx_n;
  logic [9:0] ty_n;
  logic       done_n;
  logic       active;

  function automatic logic [9:0] clamp_axis(
    input logic signed [10:0] v,
    input logic signed [10:0] hi
  );
    logic [9:0] r;
    if (v < 11'sd0)
      r = 10'd0;
    else if (v > hi)
      r = hi[9:0];
    else
      r = v[9:0];
    return r;
  endfunction

  function automatic logic signed [10:0] nudge(
    input logic [9:0] cur,
    input logic       up,
    input logic       dn
  );
    logic signed [10:0] v;
    v = $signed({1'b0, cur});
    if (up)
      v = v + STEP_S;
    else if (dn)
      v = v - STEP_S;
    return v;
  endfunction

  // Move at most STEP toward the target without overshooting it.
  function automatic logic [9:0] approach(
    input logic [9:0] cur,
    input logic [9:0] tgt
  );
    logic [10:0] d;
    logic [10:0] m;
    logic [9:0]  r;
    d = '0;
    r = cur;
    if (cur < tgt) begin
      d = {1'b0, tgt} - {1'b0, cur};
      m = (d < STEP_U) ? d : STEP_U;
      r = cur + m[9:0];
    end else if (cur > tgt) begin
      d = {1'b0, cur} - {1'b0, tgt};
      m = (d < STEP_U) ? d : STEP_U;
      r = cur - m[9:0];
    end
    return r;
  endfunction

  // frame_clk is unrelated to Clk: synchronise, then edge-detect.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_meta <= 1'b0;
      fc_sync <= 1'b0;
      fc_prev <= 1'b0;
      tick    <= 1'b0;
    end else begin
      fc_meta <= frame_clk;
      fc_sync <= fc_meta;
      fc_prev <= fc_sync;
      tick    <= fc_sync & ~fc_prev;
    end
  end

  assign active   = (status == ACTIVE_STATUS);
  assign pan_busy = (state == S_PAN);

  always_comb begin
    state_n = state;
    sx_n    = scroll_x;
    sy_n    = scroll_y;
    tx_n    = tgt_x;
    ty_n    = tgt_y;
    done_n  = 1'b0;
    if (!active) begin
      state_n = S_INACTIVE;
      sx_n    = '0;
      sy_n    = '0;
    end else begin
      case (state)
        S_INACTIVE: begin
          state_n = S_MANUAL;
          sx_n    = '0;
          sy_n    = '0;
        end
        S_MANUAL: begin
          if (pan_req) begin
            tx_n    = clamp_axis($signed({1'b0, pan_x}), X_MAX);
            ty_n    = Y_EN ? clamp_axis($signed({1'b0, pan_y}), Y_MAX)
                           : 10'd0;
            state_n = S_PAN;
          end else if (tick) begin
            sx_n = clamp_axis(nudge(scroll_x, keycode == KEY_RIGHT,
                                    keycode == KEY_LEFT), X_MAX);
            if (Y_EN)
              sy_n = clamp_axis(nudge(scroll_y, keycode == KEY_DOWN,
                                      keycode == KEY_UP), Y_MAX);
          end
        end
        S_PAN: begin
          if (tick) begin
            sx_n = approach(scroll_x, tgt_x);
            if (Y_EN)
              sy_n = approach(scroll_y, tgt_y);
            if (sx_n == tgt_x && (!Y_EN || sy_n == tgt_y)) begin
              done_n  = 1'b1;
              state_n = S_MANUAL;
            end
          end
        end
        default: state_n = S_INACTIVE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_INACTIVE;
      scroll_x <= '0;
      scroll_y <= '0;
      tgt_x    <= '0;
      tgt_y    <= '0;
      pan_done <= 1'b0;
    end else begin
      state    <= state_n;
      scroll_x <= sx_n;
      scroll_y <= sy_n;
      tgt_x    <= tx_n;
      tgt_y    <= ty_n;
      pan_done <= done_n;
    end
  end

  logic              in_x;
  logic              in_y;
  logic              hit;
  logic [9:0]        rel_x;
  logic [9:0]        rel_y;
  logic [ADDR_W-1:0] addr_n;

  assign in_x  = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI);
  assign in_y  = ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);
  assign hit   = active && in_x && in_y;
  assign rel_x = DrawX - X_LO[9:0];
  assign rel_y = DrawY - Y_LO[9:0];

  assign addr_n = ADDR_W'({1'b0, rel_y} + {1'b0, scroll_y}) * ADDR_W'(MAP_W)
                + ADDR_W'({1'b0, rel_x} + {1'b0, scroll_x});

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_map      <= 1'b0;
      map_address <= '0;
    end else begin
      is_map      <= hit;
      map_address <= hit ? addr_n : '0;
    end
  end

endmodule

// File: tb/tb_map_scroller.sv
// Scoreboard bench for map_scroller: key scroll, clamping, pan, abort, pixel addressing.
module tb_map_scroller;

  localparam int XMAX = 240;
`ifdef MAP_SCROLL_Y_EN
  localparam bit Y_EN = 1'b1;
`else
  localparam bit Y_EN = 1'b0;
`endif
  localparam int YMAX = Y_EN ? 120 : 0;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [3:0]  status = 4'd0;
  logic [7:0]  keycode = 8'd0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic        pan_req = 1'b0;
  logic [9:0]  pan_x = 10'd0;
  logic [9:0]  pan_y = 10'd0;
  logic        pan_busy;
  logic        pan_done;
  logic [9:0]  scroll_x;
  logic [9:0]  scroll_y;
  logic        is_map;
  logic [19:0] map_address;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int mx = 0;
  int my = 0;
  int tx = 0;
  int ty = 0;

  logic [19:0] sq[$];
  logic [20:0] pq[$];

  map_scroller dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .status(status), .keycode(keycode),
    .DrawX(DrawX), .DrawY(DrawY),
    .pan_req(pan_req), .pan_x(pan_x), .pan_y(pan_y),
    .pan_busy(pan_busy), .pan_done(pan_done),
    .scroll_x(scroll_x), .scroll_y(scroll_y),
    .is_map(is_map), .map_address(map_address)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (pan_done) done_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  function automatic int toward(input int c, input int t);
    return (c < t) ? c + 1 : ((c > t) ? c - 1 : c);
  endfunction

  task automatic frame_tick();
    frame_clk = 1'b1;
    repeat (6) @(posedge Clk);
    #1 frame_clk = 1'b0;
    repeat (6) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    frame_clk = 1'b0;
    keycode = 8'd0;
    pan_req = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    mx = 0;
    my = 0;
    sq.delete();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_pan(input int px, input int py);
    pan_x = 10'(px);
    pan_y = 10'(py);
    pan_req = 1'b1;
    @(posedge Clk);
    #1 pan_req = 1'b0;
    tx = clampi(px, XMAX);
    ty = Y_EN ? clampi(py, YMAX) : 0;
  endtask

  task automatic test_reset();
    logic [19:0] e;
    Reset = 1'b1;
    status = 4'd3;
    DrawX = 10'd200;
    DrawY = 10'd200;
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++;
    if ({scroll_x, scroll_y, pan_busy, pan_done, is_map, map_address} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got sx=%0d sy=%0d busy=%b done=%b map=%b addr=%0d exp all 0",
               scroll_x, scroll_y, pan_busy, pan_done, is_map, map_address);
    end
    keycode = 8'h07;
    #1 Reset = 1'b0;
    mx = 0;
    my = 0;
    sq.push_back('0);
    repeat (10) @(posedge Clk);
    #1;
    e = sq.pop_front();
    n_cmp++;
    if ({scroll_x, scroll_y} !== e) begin
      n_err++;
      $display("FAIL no_tick_without_edge: got (%0d,%0d) exp (0,0)", scroll_x, scroll_y);
    end
  endtask

  task automatic test_scroll_right();
    logic [19:0] e;
    keycode = 8'h07;
    for (int i = 0; i < 300; i++) begin
      frame_tick();
      mx = clampi(mx + 1, XMAX);
      sq.push_back({10'(mx), 10'(my)});
      e = sq.pop_front();
      n_cmp++;
      if ({scroll_x, scroll_y} !== e) begin
        n_err++;
        $display("FAIL scroll_right tick %0d: got (%0d,%0d) exp (%0d,%0d)",
                 i + 1, scroll_x, scroll_y, e[19:10], e[9:0]);
      end
    end
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    n_cmp++;
    if (scroll_x !== 10'd0 || pan_busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got sx=%0d busy=%b exp 0/0", scroll_x, pan_busy);
    end
    do_reset();
  endtask

  task automatic test_scroll_left();
    logic [19:0] e;
    logic [7:0] keys [0:9];
    keys = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04,
             8'h07, 8'h07, 8'h07, 8'h04, 8'h55};
    for (int i = 0; i < 10; i++) begin
      keycode = keys[i];
      frame_tick();
      if (keys[i] == 8'h07) mx = clampi(mx + 1, XMAX);
      if (keys[i] == 8'h04) mx = clampi(mx - 1, XMAX);
      sq.push_back({10'(mx), 10'(my)});
      e = sq.pop_front();
      n_cmp++;
      if ({scroll_x, scroll_y} !== e) begin
        n_err++;
        $display("FAIL scroll_left step %0d: got (%0d,%0d) exp (%0d,%0d)",
                 i, scroll_x, scroll_y, e[19:10], e[9:0]);
      end
    end
  endtask

  task automatic test_scroll_y();
    logic [19:0] e;
    for (int i = 0; i < 10; i++) begin
      keycode = (i < 4) ? 8'h16 : 8'h1A;
      frame_tick();
      if (Y_EN) my = clampi((i < 4) ? my + 1 : my - 1, YMAX);
      sq.push_back({10'(mx), 10'(my)});
      e = sq.pop_front();
      n_cmp++;
      if ({scroll_x, scroll_y} !== e) begin
        n_err++;
        $display("FAIL scroll_y step %0d: got (%0d,%0d) exp (%0d,%0d)",
                 i, scroll_x, scroll_y, e[19:10], e[9:0]);
      end
    end
    keycode = 8'd0;
  endtask

  task automatic run_pan(input string nm, input int max_ticks, input int base);
    logic [19:0] e;
    int exp_done;
    for (int i = 0; i < max_ticks; i++) begin
      frame_tick();
      mx = toward(mx, tx);
      my = toward(my, ty);
      sq.push_back({10'(mx), 10'(my)});
      exp_done = (mx == tx && my == ty) ? 1 : 0;
      e = sq.pop_front();
      n_cmp++;
      if ({scroll_x, scroll_y} !== e || (done_cnt - base) != exp_done) begin
        n_err++;
        $display("FAIL %s tick %0d: got (%0d,%0d) done=%0d exp (%0d,%0d) done=%0d",
                 nm, i + 1, scroll_x, scroll_y, done_cnt - base,
                 e[19:10], e[9:0], exp_done);
      end
      if (exp_done == 1) break;
    end
  endtask

  task automatic test_pan();
    int base;
    do_reset();
    keycode = 8'h04;
    start_pan(100, 50);
    n_cmp++;
    if (pan_busy !== 1'b1) begin
      n_err++;
      $display("FAIL pan_busy_start: got %b exp 1", pan_busy);
    end
    base = done_cnt;
    run_pan("pan_100_50", 100, base);
    n_cmp++;
    if (pan_busy !== 1'b0 || done_cnt - base != 1 || scroll_x !== 10'd100) begin
      n_err++;
      $display("FAIL pan_finish: got busy=%b done=%0d sx=%0d exp 0/1/100",
               pan_busy, done_cnt - base, scroll_x);
    end
    keycode = 8'd0;
  endtask

  task automatic test_pan_clamp();
    int base;
    start_pan(900, 900);
    base = done_cnt;
    run_pan("pan_clamp", 200, base);
    frame_tick();
    frame_tick();
    n_cmp++;
    if ({scroll_x, scroll_y} !== {10'(XMAX), 10'(YMAX)} || done_cnt - base != 1
        || pan_busy !== 1'b0) begin
      n_err++;
      $display("FAIL pan_clamp_final: got (%0d,%0d) done=%0d busy=%b exp (%0d,%0d) 1 0",
               scroll_x, scroll_y, done_cnt - base, pan_busy, XMAX, YMAX);
    end
    base = done_cnt;
    start_pan(mx, my);
    frame_tick();
    n_cmp++;
    if (done_cnt - base != 1 || pan_busy !== 1'b0) begin
      n_err++;
      $display("FAIL pan_same_target: got done=%0d busy=%b exp 1 0",
               done_cnt - base, pan_busy);
    end
  endtask

  task automatic test_pan_ignored();
    int base;
    status = 4'd2;
    @(posedge Clk);
    #1;
    mx = 0;
    my = 0;
    start_pan(50, 20);
    n_cmp++;
    if (pan_busy !== 1'b0) begin
      n_err++;
      $display("FAIL pan_in_inactive: got busy=%b exp 0", pan_busy);
    end
    status = 4'd3;
    @(posedge Clk);
    #1;
    start_pan(50, 20);
    base = done_cnt;
    frame_tick();
    mx = toward(mx, tx);
    my = toward(my, ty);
    pan_x = 10'd0;
    pan_y = 10'd0;
    pan_req = 1'b1;
    @(posedge Clk);
    #1 pan_req = 1'b0;
    run_pan("pan_ignore_repan", 60, base);
    n_cmp++;
    if (scroll_x !== 10'd50 || done_cnt - base != 1) begin
      n_err++;
      $display("FAIL pan_in_pan_ignored: got sx=%0d done=%0d exp 50 1",
               scroll_x, done_cnt - base);
    end
  endtask

  task automatic test_abort();
    int base;
    start_pan(200, 100);
    base = done_cnt;
    repeat (5) frame_tick();
    status = 4'd2;
    @(posedge Clk);
    #1;
    n_cmp++;
    if ({scroll_x, scroll_y} !== '0 || pan_busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: got (%0d,%0d) busy=%b exp (0,0) 0",
               scroll_x, scroll_y, pan_busy);
    end
    status = 4'd3;
    repeat (3) frame_tick();
    n_cmp++;
    if (done_cnt != base || scroll_x !== 10'd0) begin
      n_err++;
      $display("FAIL abort_no_done: got done=%0d sx=%0d exp 0 0",
               done_cnt - base, scroll_x);
    end
    mx = 0;
    my = 0;
  endtask

  task automatic test_pixel();
    logic [20:0] e;
    int hit;
    int xs [0:8];
    int ys [0:8];
    int base;
    xs = '{130, 640, 639, 129, 300, 400, 0, 639, 200};
    ys = '{180, 180, 299, 250, 300, 250, 0, 180, 200};
    do_reset();
    status = 4'd3;
    @(posedge Clk);
    #1;
    start_pan(10, 5);
    base = done_cnt;
    run_pan("pan_to_10_5", 20, base);
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) begin
        e = pq.pop_front();
        n_cmp++;
        if ({is_map, map_address} !== e) begin
          n_err++;
          $display("FAIL pixel %0d: got map=%b addr=%0d exp map=%b addr=%0d",
                   i - 1, is_map, map_address, e[20], e[19:0]);
        end
      end
      if (i < 9) begin
        DrawX = 10'(xs[i]);
        DrawY = 10'(ys[i]);
        if (i == 8) status = 4'd2;
        hit = (status == 4'd3 && xs[i] >= 130 && xs[i] < 640
               && ys[i] >= 180 && ys[i] < 300) ? 1 : 0;
        pq.push_back(hit != 0
          ? {1'b1, 20'((ys[i] - 180 + my) * 750 + (xs[i] - 130 + mx))}
          : 21'd0);
        @(posedge Clk);
        #1;
      end
    end
    status = 4'd3;
  endtask

  initial begin
    test_reset();
    test_scroll_right();
    status = 4'd3;
    @(posedge Clk);
    #1;
    test_scroll_left();
    test_scroll_y();
    test_pan();
    test_pan_clamp();
    test_pan_ignored();
    test_abort();
    test_pixel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
